// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline sequencing controller for the five-stage MIPS core.
// It compares operand need times (T_use) in D with result ready times
// (T_new) in E and M to freeze PC and F/D and to bubble D/E.
// It also sequences the multiply/divide unit (MDU): it holds
// MDU-dependent D instructions while an operation is in flight and
// pulses mdu_done on the cycle HI/LO are written.
// An exception request (req) overrides every stall.
//
// Optional feature: define HCU_STALL_CNT_EN to build a saturating
// stall-cycle counter on stall_cnt. Without it, stall_cnt reads zero
// and no counter flops are built.

module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [1:0]  D_T_use_rs,
   input  logic [1:0]  D_T_use_rt,
   input  logic        D_is_mdu,
   input  logic [4:0]  E_WriteRegAddr,
   input  logic [4:0]  M_WriteRegAddr,
   input  logic        E_CU_EN_RegWrite,
   input  logic        M_CU_EN_RegWrite,
   input  logic [1:0]  E_T_new,
   input  logic [1:0]  M_T_new,
   input  logic        E_mdu_start,
   input  logic        E_mdu_is_div,
   output logic        HCU_EN_PC,
   output logic        HCU_EN_FD,
   output logic        HCU_EN_DE,
   output logic        HCU_EN_EM,
   output logic        HCU_EN_MW,
   output logic        HCU_flush_DE,
   output logic        mdu_busy,
   output logic        mdu_done,
   output logic [31:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] MULT_LD  = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(DIV_CYCLES);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_t;

   // A source operand stalls when a not-yet-ready producer in E or M
   // targets it. Register 0 never stalls; W results are forwarded.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [1:0] t_use,
      input logic       e_we,
      input logic [4:0] e_addr,
      input logic [1:0] e_tnew,
      input logic       m_we,
      input logic [4:0] m_addr,
      input logic [1:0] m_tnew
   );
      logic e_hit;
      logic m_hit;
      e_hit = e_we && (e_addr == src) && (e_tnew > t_use);
      m_hit = m_we && (m_addr == src) && (m_tnew > t_use);
      return (src != 5'd0) && (t_use != 2'b11) && (e_hit || m_hit);
   endfunction

   mdu_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             stall_rs_s, stall_rt_s, stall_mdu_s, stall_s;

   // Hazard detection for both source operands and the MDU.
   always_comb begin
      stall_rs_s  = src_hazard(D_rs, D_T_use_rs,
                               E_CU_EN_RegWrite, E_WriteRegAddr, E_T_new,
                               M_CU_EN_RegWrite, M_WriteRegAddr, M_T_new);
      stall_rt_s  = src_hazard(D_rt, D_T_use_rt,
                               E_CU_EN_RegWrite, E_WriteRegAddr, E_T_new,
                               M_CU_EN_RegWrite, M_WriteRegAddr, M_T_new);
      stall_mdu_s = D_is_mdu && (mdu_busy || E_mdu_start);
      stall_s     = stall_rs_s || stall_rt_s || stall_mdu_s;
   end

   // Stage enables: freeze PC and F/D and bubble D/E on a stall, unless a request flushes.
   always_comb begin
      HCU_EN_DE = 1'b1;
      HCU_EN_EM = 1'b1;
      HCU_EN_MW = 1'b1;
      if (stall_s && !req) begin
         HCU_EN_PC    = 1'b0;
         HCU_EN_FD    = 1'b0;
         HCU_flush_DE = 1'b1;
      end else begin
         HCU_EN_PC    = 1'b1;
         HCU_EN_FD    = 1'b1;
         HCU_flush_DE = 1'b0;
      end
   end

   // MDU sequencer state register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_ZERO;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // MDU next state: a start concurrent with req is cancelled; a running op ignores req.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (E_mdu_start && !req) begin
               state_d = ST_BUSY;
               cnt_d   = E_mdu_is_div ? DIV_LD : MULT_LD;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end
         end
         ST_BUSY: begin
            if (cnt_q <= CNT_ONE) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = ST_BUSY;
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
      // The done pulse is registered: it rises in the last busy cycle.
      done_d = (state_d == ST_BUSY) && (cnt_d == CNT_ONE);
   end

   // MDU outputs decoded from registered state only.
   always_comb begin
      mdu_busy = (state_q == ST_BUSY);
      mdu_done = done_q;
   end

`ifdef HCU_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   // Saturating count of cycles in which the pipeline front end was held.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'h0000_0000;
      end else if (stall_s && !req && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'h0000_0001;
      end else begin
         stall_cnt_q <= stall_cnt_q;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a table of combinational
// hazard vectors followed by hand-written MDU sequences.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset, req;
   logic [4:0]  D_rs, D_rt, E_WriteRegAddr, M_WriteRegAddr;
   logic [1:0]  D_T_use_rs, D_T_use_rt, E_T_new, M_T_new;
   logic        D_is_mdu, E_CU_EN_RegWrite, M_CU_EN_RegWrite;
   logic        E_mdu_start, E_mdu_is_div;
   logic        HCU_EN_PC, HCU_EN_FD, HCU_EN_DE, HCU_EN_EM, HCU_EN_MW;
   logic        HCU_flush_DE, mdu_busy, mdu_done;
   logic [31:0] stall_cnt;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [5:0] EN_RUN   = 6'b111110;
   localparam logic [5:0] EN_STALL = 6'b001111;
`ifdef HCU_STALL_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .req(req),
      .D_rs(D_rs), .D_rt(D_rt), .D_T_use_rs(D_T_use_rs), .D_T_use_rt(D_T_use_rt),
      .D_is_mdu(D_is_mdu),
      .E_WriteRegAddr(E_WriteRegAddr), .M_WriteRegAddr(M_WriteRegAddr),
      .E_CU_EN_RegWrite(E_CU_EN_RegWrite), .M_CU_EN_RegWrite(M_CU_EN_RegWrite),
      .E_T_new(E_T_new), .M_T_new(M_T_new),
      .E_mdu_start(E_mdu_start), .E_mdu_is_div(E_mdu_is_div),
      .HCU_EN_PC(HCU_EN_PC), .HCU_EN_FD(HCU_EN_FD), .HCU_EN_DE(HCU_EN_DE),
      .HCU_EN_EM(HCU_EN_EM), .HCU_EN_MW(HCU_EN_MW), .HCU_flush_DE(HCU_flush_DE),
      .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs;  logic [4:0] rt;
      logic [1:0] tu_rs; logic [1:0] tu_rt;
      logic       is_mdu;
      logic       e_we; logic [4:0] e_a; logic [1:0] e_tn;
      logic       m_we; logic [4:0] m_a; logic [1:0] m_tn;
      logic       rq;  logic start;
      logic [5:0] exp_en;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] en_vec();
      return {26'd0, HCU_EN_PC, HCU_EN_FD, HCU_EN_DE, HCU_EN_EM, HCU_EN_MW, HCU_flush_DE};
   endfunction

   // Advance one clock; outputs are then sampled away from the active edge.
   task automatic tick();
      if (E_mdu_start && mdu_busy) begin
         vectors++;
         miscompares++;
         $display("FAIL start_while_busy: got 1, expected 0 at %0t", $time);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req = 1'b0; D_rs = 5'd0; D_rt = 5'd0; D_T_use_rs = 2'b11; D_T_use_rt = 2'b11;
      D_is_mdu = 1'b0; E_WriteRegAddr = 5'd0; M_WriteRegAddr = 5'd0;
      E_CU_EN_RegWrite = 1'b0; M_CU_EN_RegWrite = 1'b0; E_T_new = 2'd0; M_T_new = 2'd0;
      E_mdu_start = 1'b0; E_mdu_is_div = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
      chk("rst_done", {31'd0, mdu_done}, 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      int done_seen;
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);

      //          rs    rt    tu_rs tu_rt mdu  e_we e_a   e_tn m_we m_a   m_tn rq   st   exp
      tbl[0]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, EN_RUN};
      tbl[1]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 1'b1, 5'd8, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, EN_STALL};
      tbl[2]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, EN_RUN};
      tbl[3]  = '{5'd0, 5'd0, 2'd1, 2'd3, 1'b0, 1'b1, 5'd0, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, EN_RUN};
      tbl[4]  = '{5'd0, 5'd9, 2'd3, 2'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0, EN_STALL};
      tbl[5]  = '{5'd0, 5'd9, 2'd3, 2'd3, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0, EN_RUN};
      tbl[6]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 1'b0, 5'd8, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, EN_RUN};
      tbl[7]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 1'b1, 5'd8, 2'd2, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, EN_RUN};
      tbl[8]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, EN_RUN};
      tbl[9]  = '{5'd8, 5'd0, 2'd0, 2'd3, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, EN_STALL};
      tbl[10] = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 1'b1, 5'd9, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, EN_RUN};
      tbl[11] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, EN_RUN};
      tbl[12] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, EN_RUN};
      tbl[13] = '{5'd8, 5'd8, 2'd3, 2'd1, 1'b0, 1'b1, 5'd8, 2'd2, 1'b1, 5'd8, 2'd0, 1'b0, 1'b0, EN_STALL};
      tbl[14] = '{5'd5, 5'd0, 2'd1, 2'd3, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0, EN_STALL};

      do_reset();

      // Table: combinational enables, and the MDU must never leave IDLE.
      for (int i = 0; i < 15; i++) begin
         D_rs = tbl[i].rs; D_rt = tbl[i].rt;
         D_T_use_rs = tbl[i].tu_rs; D_T_use_rt = tbl[i].tu_rt;
         D_is_mdu = tbl[i].is_mdu;
         E_CU_EN_RegWrite = tbl[i].e_we; E_WriteRegAddr = tbl[i].e_a; E_T_new = tbl[i].e_tn;
         M_CU_EN_RegWrite = tbl[i].m_we; M_WriteRegAddr = tbl[i].m_a; M_T_new = tbl[i].m_tn;
         req = tbl[i].rq; E_mdu_start = tbl[i].start; E_mdu_is_div = 1'b0;
         #1;
         chk($sformatf("vec%0d_en", i), en_vec(), {26'd0, tbl[i].exp_en});
         tick();
         chk($sformatf("vec%0d_busy", i), {31'd0, mdu_busy}, 32'd0);
         chk($sformatf("vec%0d_done", i), {31'd0, mdu_done}, 32'd0);
      end
      idle_inputs();

      // mult issued with mflo waiting in D.
      do_reset();
      E_mdu_start = 1'b1; E_mdu_is_div = 1'b0; D_is_mdu = 1'b1;
      #1;
      chk("mult_t_en", en_vec(), {26'd0, EN_STALL});
      tick();
      E_mdu_start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         #1;
         chk($sformatf("mult_t%0d_busy", k), {31'd0, mdu_busy}, 32'd1);
         chk($sformatf("mult_t%0d_done", k), {31'd0, mdu_done}, {31'd0, (k == 5)});
         chk($sformatf("mult_t%0d_en", k), en_vec(), {26'd0, EN_STALL});
         tick();
      end
      #1;
      chk("mult_t6_busy", {31'd0, mdu_busy}, 32'd0);
      chk("mult_t6_done", {31'd0, mdu_done}, 32'd0);
      chk("mult_t6_en", en_vec(), {26'd0, EN_RUN});
      chk("mult_stall_cnt", stall_cnt, CNT_ON ? 32'd6 : 32'd0);
      idle_inputs();
      tick();

      // div; a req in the middle neither aborts it nor stalls.
      E_mdu_start = 1'b1; E_mdu_is_div = 1'b1;
      tick();
      E_mdu_start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k == 3) begin
            req = 1'b1; D_is_mdu = 1'b1;
         end
         #1;
         chk($sformatf("div_t%0d_busy", k), {31'd0, mdu_busy}, 32'd1);
         chk($sformatf("div_t%0d_done", k), {31'd0, mdu_done}, {31'd0, (k == 10)});
         if (k == 3) chk("div_req_en", en_vec(), {26'd0, EN_RUN});
         tick();
         req = 1'b0; D_is_mdu = 1'b0;
      end
      #1;
      chk("div_t11_busy", {31'd0, mdu_busy}, 32'd0);
      chk("div_t11_done", {31'd0, mdu_done}, 32'd0);

      // Reset in the third busy cycle of a div aborts without a done pulse.
      do_reset();
      E_mdu_start = 1'b1; E_mdu_is_div = 1'b1; D_is_mdu = 1'b1;
      tick();
      E_mdu_start = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         #1;
         chk($sformatf("abort_t%0d_busy", k), {31'd0, mdu_busy}, 32'd1);
         tick();
      end
      #1;
      chk("abort_t3_busy", {31'd0, mdu_busy}, 32'd1);
      chk("abort_t3_stall_cnt", stall_cnt, CNT_ON ? 32'd3 : 32'd0);
      reset = 1'b1;
      #1;
      chk("abort_rst_en", en_vec(), {26'd0, EN_STALL});
      tick();
      chk("abort_busy", {31'd0, mdu_busy}, 32'd0);
      chk("abort_done", {31'd0, mdu_done}, 32'd0);
      chk("abort_stall_cnt", stall_cnt, 32'd0);
      reset = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (mdu_done || mdu_busy) done_seen++;
      end
      chk("abort_no_done", done_seen, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the five-stage MIPS core. Generates stage-register enables (`HCU_EN_PC`, `HCU_EN_FD`, `HCU_EN_DE`, `HCU_EN_EM`, `HCU_EN_MW`) and D/E bubble insertion from T_use/T_new hazard comparison. Owns the multiply/divide busy sequencer that schedules HI/LO writeback and blocks MDU-dependent instructions in D. Exception request `req` overrides all stalls.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy cycles for mult/multu
- `DIV_CYCLES`, 10, busy cycles for div/divu
- `CNT_W`, 4, MDU counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 system clock
- `reset` in 1 synchronous active-high reset
- `req` in 1 exception/interrupt request from CP0; flushes pipeline
- `D_rs`, `D_rt` in 5 source register numbers in D
- `D_T_use_rs`, `D_T_use_rt` in 2 cycles until operand needed; 2'b11 = not used
- `D_is_mdu` in 1 D holds mult/div/mfhi/mflo/mthi/mtlo
- `E_WriteRegAddr`, `M_WriteRegAddr` in 5 destination registers
- `E_CU_EN_RegWrite`, `M_CU_EN_RegWrite` in 1 destination write enables
- `E_T_new`, `M_T_new` in 2 cycles until result available
- `E_mdu_start` in 1 E holds mult/multu/div/divu this cycle
- `E_mdu_is_div` in 1 qualifies `E_mdu_start`: 1 = div/divu
- `HCU_EN_PC`, `HCU_EN_FD`, `HCU_EN_DE`, `HCU_EN_EM`, `HCU_EN_MW` out 1 stage enables
- `HCU_flush_DE` out 1 clear D/E register (bubble)
- `mdu_busy` out 1 MDU operation in flight
- `mdu_done` out 1 one-cycle pulse: write HI/LO this cycle
- `stall_cnt` out 32 stall-cycle counter (see Configuration)

## Operation
- Data hazard, per source s in {rs, rt}: `stall_s` = s≠0 and T_use_s≠3 and ((E_CU_EN_RegWrite and E_WriteRegAddr==s and E_T_new>T_use_s) or (M_CU_EN_RegWrite and M_WriteRegAddr==s and M_T_new>T_use_s)). W never stalls (forwarded).
- MDU hazard: `stall_mdu` = D_is_mdu and (mdu_busy or E_mdu_start).
- `stall` = stall_rs | stall_rt | stall_mdu.
- `stall` and not `req`: HCU_EN_PC=0, HCU_EN_FD=0, HCU_flush_DE=1, HCU_EN_DE/EM/MW=1.
- `req`: all enables 1, HCU_flush_DE=0; stage registers clear on `req` themselves; stall ignored.
- Otherwise: all enables 1, HCU_flush_DE=0.
- MDU FSM, states IDLE/BUSY, counter `cnt` (CNT_W bits):
  - IDLE, E_mdu_start and not req: load cnt = E_mdu_is_div ? DIV_CYCLES : MULT_CYCLES, go BUSY.
  - BUSY: cnt decrements each cycle; at cnt==1, mdu_done=1, next state IDLE, cnt=0.
  - E_mdu_start coinciding with req: cancelled, stay IDLE.
  - req during BUSY: operation completes normally (instruction already committed past E).
  - E_mdu_start while BUSY: ignored (cannot occur given stall_mdu; bench asserts it never does).
- `mdu_busy` = (state==BUSY); registered.

## Timing
- Enables and HCU_flush_DE combinational, same cycle as inputs.
- Start sampled at edge t: mdu_busy high cycles t+1..t+N (N = MULT_CYCLES or DIV_CYCLES); mdu_done high cycle t+N only; mdu_busy low at t+N+1.
- D instruction stalled on MDU issues in cycle t+N+1.
- Reset: state IDLE, cnt=0, mdu_busy=0, mdu_done=0, stall_cnt=0; reset mid-operation aborts with no mdu_done pulse. Combinational outputs follow inputs during reset.

## Configuration
- `HCU_STALL_CNT_EN` defined: `stall_cnt` increments on every cycle with stall=1 and req=0, saturates at 32'hFFFF_FFFF, cleared by reset.
- Undefined: `stall_cnt` tied to 32'h0000_0000, no counter flops.

## Test plan
- E lw writes $8 (E_T_new=2), D addu reads $8 (T_use=1) -> HCU_EN_PC=0, HCU_EN_FD=0, HCU_flush_DE=1 one cycle; next cycle (M_T_new=1) no stall.
- Same hazard with D rs=0 -> no stall, all enables 1.
- mult start at edge t, D mflo from t+1 -> mdu_busy high t+1..t+5, mdu_done only at t+5, stall cycles t..t+5, mflo issues t+6; stall_cnt=6 with `HCU_STALL_CNT_EN`.
- div start -> mdu_busy 10 cycles, mdu_done at t+10.
- E_mdu_start with req same cycle -> mdu_busy stays 0, no mdu_done; req with concurrent data hazard -> HCU_flush_DE=0, all enables 1.
- reset asserted at t+3 of a div -> mdu_busy=0 next cycle, no mdu_done, stall_cnt=0.
